// File: rtl/fft_pkg.sv
// Shared constants, read-FSM encoding and sample conversion for the FFT frame buffer.
package fft_pkg;

   localparam int N_POINTS = 8;
   localparam int DATA_W   = 8;
   localparam int IDX_W    = $clog2(N_POINTS);
   localparam int FRAME_W  = N_POINTS * DATA_W;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_t;

   // Offset binary to two's complement is an MSB flip; raw mode passes through.
   function automatic logic [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] s,
                                                 input logic offset_binary);
      if (offset_binary)
         return {~s[DATA_W-1], s[DATA_W-2:0]};
      else
         return s;
   endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample-in / frame-out bundle between the ADC receiver, the frame buffer and stage 1.
// Handshake: i_Sample_DV and i_FFT_Done are single-cycle strobes with no back-pressure;
// o_Start is a single-cycle strobe and o_Data stays stable from o_Start until the next o_Start.
interface fft_frame_buffer_if;
   import fft_pkg::*;

   logic                  i_Sample_DV;
   logic [DATA_W-1:0]     i_Sample;
   logic                  i_FFT_Done;
   logic                  i_Clear_Ovf;
   logic                  o_Start;
   logic [FRAME_W-1:0]    o_Data;
   logic                  o_Busy;
   logic                  o_Overflow;
   rd_state_t             dbg_state;

   modport master (
      output i_Sample_DV, i_Sample, i_FFT_Done, i_Clear_Ovf,
      input  o_Start, o_Data, o_Busy, o_Overflow, dbg_state
   );

   modport slave (
      input  i_Sample_DV, i_Sample, i_FFT_Done, i_Clear_Ovf,
      output o_Start, o_Data, o_Busy, o_Overflow, dbg_state
   );

endinterface

// File: rtl/fft_bank_regs.sv
// One frame bank: N_POINTS x DATA_W registers, single write port, whole frame readable.
module fft_bank_regs
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               rst_l,
   input  logic               we,
   input  logic [IDX_W-1:0]   idx,
   input  logic [DATA_W-1:0]  data,
   output logic [FRAME_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [N_POINTS];

   // Clear the bank on reset, otherwise write one sample when enabled.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         for (int k = 0; k < N_POINTS; k++) mem[k] <= '0;
      end else if (we) begin
         mem[idx] <= data;
      end
   end

   // Flatten the bank so sample k sits at bits [k*DATA_W +: DATA_W].
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N_POINTS; k++) rd_data[k*DATA_W +: DATA_W] = mem[k];
   end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: fills one bank from the ADC while the FFT reads the other,
// swapping banks and pulsing o_Start whenever a full frame can be handed over.
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter bit OFFSET_BINARY = 1'b1
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   fft_frame_buffer_if.slave  bus
);

   rd_state_t          state_q, state_d;
   logic [IDX_W-1:0]   wr_idx_q;
   logic               wr_bank_q, rd_bank_q;
   logic               pending_q, pending_d;
   logic               start_q;
   logic               ovf_q;
   logic               swap;
   logic               capture, drop, frame_done;
   logic [DATA_W-1:0]  cap_data;
   logic [FRAME_W-1:0] frame0, frame1;

   // A pending frame locks the write bank, so any sample arriving then is dropped.
   assign capture    = bus.i_Sample_DV & ~pending_q;
   assign drop       = bus.i_Sample_DV & pending_q;
   assign frame_done = capture && (wr_idx_q == IDX_W'(N_POINTS - 1));
   assign cap_data   = to_twos(bus.i_Sample, OFFSET_BINARY);

   fft_bank_regs u_bank0 (
      .clk     (i_Clk),
      .rst_l   (i_Rst_L),
      .we      (capture & ~wr_bank_q),
      .idx     (wr_idx_q),
      .data    (cap_data),
      .rd_data (frame0)
   );

   fft_bank_regs u_bank1 (
      .clk     (i_Clk),
      .rst_l   (i_Rst_L),
      .we      (capture & wr_bank_q),
      .idx     (wr_idx_q),
      .data    (cap_data),
      .rd_data (frame1)
   );

   // Read FSM: decide when to swap banks and when a completed frame must wait.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      swap      = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (frame_done || pending_q) begin
               swap      = 1'b1;
               pending_d = 1'b0;
               state_d   = RD_BUSY;
            end
         end
         RD_BUSY: begin
            if (bus.i_FFT_Done) begin
               // A frame finishing in the same cycle as done is handed over directly.
               if (pending_q || frame_done) begin
                  swap      = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  state_d = RD_IDLE;
               end
            end else if (frame_done) begin
               pending_d = 1'b1;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Registered control: FSM state, write pointer, bank selects, start pulse, overflow.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q   <= RD_IDLE;
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b1;
         pending_q <= 1'b0;
         start_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         start_q   <= swap;
         if (capture) wr_idx_q <= frame_done ? '0 : wr_idx_q + IDX_W'(1);
         if (swap) begin
            rd_bank_q <= wr_bank_q;
            wr_bank_q <= ~wr_bank_q;
         end
         if (drop)                 ovf_q <= 1'b1;
         else if (bus.i_Clear_Ovf) ovf_q <= 1'b0;
      end
   end

   assign bus.o_Start    = start_q;
   assign bus.o_Data     = rd_bank_q ? frame1 : frame0;
   assign bus.o_Busy     = (state_q == RD_BUSY);
   assign bus.o_Overflow = ovf_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: directed steps then random traffic against a frame-level model.
module tb_fft_frame_buffer;
   import fft_pkg::*;

   // Clock and reset
   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #31 clk = ~clk;

   fft_frame_buffer_if ifc ();
   fft_frame_buffer_if ifr ();

   fft_frame_buffer #(.OFFSET_BINARY(1'b1)) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_l),
      .bus     (ifc.slave)
   );

   fft_frame_buffer #(.OFFSET_BINARY(1'b0)) dut_raw (
      .i_Clk   (clk),
      .i_Rst_L (rst_l),
      .bus     (ifr.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state, in terms of frames rather than registers
   logic [DATA_W-1:0]  m_cur[$];
   logic [FRAME_W-1:0] m_shown, m_pend;
   bit                 m_pend_v, m_busy, m_ovf, m_start, prev_start;

   // Scoreboard: frames expected to appear with each o_Start
   logic [FRAME_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [FRAME_W-1:0] obs,
                        input logic [FRAME_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit dv, input logic [DATA_W-1:0] s,
                             input bit done, input bit clr);
      logic [FRAME_W-1:0] fr;
      bit complete, dropped;
      fr = '0;
      complete = 0;
      dropped  = 0;
      m_start  = 0;
      if (!rst_l) begin
         m_cur.delete();
         m_shown  = '0;
         m_pend   = '0;
         m_pend_v = 0;
         m_busy   = 0;
         m_ovf    = 0;
         exp_q.delete();
         return;
      end
      if (dv) begin
         if (m_pend_v) dropped = 1;
         else begin
            // offset binary minus midscale gives the signed value
            m_cur.push_back(s - DATA_W'(1 << (DATA_W - 1)));
            if (m_cur.size() == N_POINTS) begin
               for (int k = 0; k < N_POINTS; k++) fr[k*DATA_W +: DATA_W] = m_cur[k];
               m_cur.delete();
               complete = 1;
            end
         end
      end
      if (dropped)  m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (!m_busy) begin
         if (complete) begin
            m_shown = fr; m_busy = 1; m_start = 1;
         end
      end else if (done) begin
         if (m_pend_v) begin
            m_shown = m_pend; m_pend_v = 0; m_start = 1;
         end else if (complete) begin
            m_shown = fr; m_start = 1;
         end else begin
            m_busy = 0;
         end
      end else if (complete) begin
         m_pend = fr; m_pend_v = 1;
      end
      if (m_start) exp_q.push_back(m_shown);
   endtask

   // Driver: apply one cycle of inputs, advance the model, check outputs after the edge
   task automatic cycle(input bit dv, input logic [DATA_W-1:0] s,
                        input bit done, input bit clr);
      ifc.i_Sample_DV = dv;
      ifc.i_Sample    = s;
      ifc.i_FFT_Done  = done;
      ifc.i_Clear_Ovf = clr;
      @(posedge clk);
      model_step(dv, s, done, clr);
      #1;
      check("start", FRAME_W'(ifc.o_Start), FRAME_W'(m_start));
      check("busy", FRAME_W'(ifc.o_Busy), FRAME_W'(m_busy));
      check("overflow", FRAME_W'(ifc.o_Overflow), FRAME_W'(m_ovf));
      check("data", ifc.o_Data, m_shown);
      check("start_not_back_to_back", FRAME_W'(prev_start & ifc.o_Start), '0);
      if (ifc.o_Start) begin
         if (exp_q.size() == 0) check("sb_unexpected_start", FRAME_W'(1), '0);
         else                   check("sb_frame", ifc.o_Data, exp_q.pop_front());
      end
      prev_start = ifc.o_Start;
      ifc.i_Sample_DV = 1'b0;
      ifc.i_FFT_Done  = 1'b0;
      ifc.i_Clear_Ovf = 1'b0;
   endtask

   task automatic feed(input logic [DATA_W-1:0] b);
      cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   logic [DATA_W-1:0] frame_a [N_POINTS] = '{8'h80, 8'hD2, 8'hFE, 8'hEE,
                                             8'hAB, 8'h55, 8'h12, 8'h02};

   initial begin
      ifc.i_Sample_DV = 1'b0; ifc.i_Sample = '0; ifc.i_FFT_Done = 1'b0; ifc.i_Clear_Ovf = 1'b0;
      ifr.i_Sample_DV = 1'b0; ifr.i_Sample = '0; ifr.i_FFT_Done = 1'b0; ifr.i_Clear_Ovf = 1'b0;
      prev_start = 0;

      // Reset state
      rst_l = 1'b0;
      cycle(0, '0, 0, 0);
      cycle(0, '0, 0, 0);
      check("reset_data_zero", ifc.o_Data, '0);
      check("reset_busy_zero", FRAME_W'(ifc.o_Busy), '0);
      rst_l = 1'b1;
      cycle(0, '0, 0, 0);

      // First frame: start one cycle after the 8th DV
      for (int k = 0; k < N_POINTS; k++) feed(frame_a[k]);
      check("frame_a_start", FRAME_W'(ifc.o_Start), FRAME_W'(1));
      check("frame_a_data", ifc.o_Data, 64'h8292D52B6E7E5200);
      check("frame_a_busy", FRAME_W'(ifc.o_Busy), FRAME_W'(1));
      cycle(0, '0, 0, 0);

      // Second frame while busy, then one extra sample that must be dropped
      for (int k = 0; k < N_POINTS; k++) feed(DATA_W'(8'h10 + 8'(k * 17)));
      feed(8'hFF);
      check("ovf_set", FRAME_W'(ifc.o_Overflow), FRAME_W'(1));
      check("frame_a_held", ifc.o_Data, 64'h8292D52B6E7E5200);
      cycle(0, '0, 0, 0);

      // Release: the pending frame is handed over
      cycle(0, '0, 1, 0);
      check("pending_start", FRAME_W'(ifc.o_Start), FRAME_W'(1));
      cycle(0, '0, 0, 1);
      check("ovf_cleared", FRAME_W'(ifc.o_Overflow), '0);

      // 8th DV coincides with done
      for (int k = 0; k < N_POINTS - 1; k++) feed(DATA_W'($urandom_range(0, 255)));
      cycle(1, 8'h3C, 1, 0);
      check("coincident_start", FRAME_W'(ifc.o_Start), FRAME_W'(1));
      check("coincident_no_ovf", FRAME_W'(ifc.o_Overflow), '0);
      cycle(0, '0, 0, 0);
      check("coincident_single_start", FRAME_W'(ifc.o_Start), '0);
      cycle(0, '0, 1, 0);

      // Reset mid-frame discards everything
      for (int k = 0; k < 5; k++) feed(DATA_W'($urandom_range(0, 255)));
      rst_l = 1'b0;
      cycle(0, '0, 0, 0);
      check("midreset_data", ifc.o_Data, '0);
      check("midreset_busy", FRAME_W'(ifc.o_Busy), '0);
      check("midreset_ovf", FRAME_W'(ifc.o_Overflow), '0);
      rst_l = 1'b1;
      cycle(0, '0, 1, 0);
      for (int k = 0; k < N_POINTS; k++) feed(frame_a[k]);
      check("post_reset_frame", ifc.o_Data, 64'h8292D52B6E7E5200);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         cycle(bit'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 255)),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 19) == 0));
      end

      // Raw (non-offset) instance
      for (int k = 0; k < N_POINTS; k++) begin
         ifr.i_Sample_DV = 1'b1;
         ifr.i_Sample    = DATA_W'(k);
         @(posedge clk);
         #1;
      end
      ifr.i_Sample_DV = 1'b0;
      check("raw_start", FRAME_W'(ifr.o_Start), FRAME_W'(1));
      check("raw_data", ifr.o_Data, 64'h0706050403020100);

      // Final report
      check("sb_drained", FRAME_W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
